// File: rtl/mem_access_unit.sv
// Multicycle memory front-end: turns control-unit strobes into a valid/ready
// request plus response transaction and holds the IR / MDR.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        i_or_d,
    input  logic        IR_write,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] inst_reg,
    output logic [31:0] mem_data_reg,
    output logic        access_fault
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dest_ir;
    logic [31:0]   addr_sel;
    logic          bad_access;

    assign addr_sel   = i_or_d ? alu_out : pc;
    assign bad_access = (mem_read & mem_write) | (addr_sel[1:0] != 2'b00);

    // Combinational so the control unit holds in the very cycle it asks.
    assign stall = ((state == IDLE) & (mem_read | mem_write)) |
                   (state == REQ) | (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dest_ir      <= 1'b0;
            req_valid    <= 1'b0;
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            done         <= 1'b0;
            inst_reg     <= '0;
            mem_data_reg <= '0;
            access_fault <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        req_addr  <= addr_sel;
                        req_we    <= mem_write;
                        req_wdata <= write_data;
                        dest_ir   <= IR_write & ~i_or_d;
                        if (bad_access) begin
                            access_fault <= 1'b1;
                            done         <= 1'b1;
                            state        <= DONE;
                        end else begin
                            req_valid <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (req_we) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt   <= '0;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving on the last allowed cycle beats the timeout.
                    if (resp_valid) begin
                        if (dest_ir) inst_reg <= resp_data;
                        else         mem_data_reg <= resp_data;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cnt == TMAX) begin
                        access_fault <= 1'b1;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected {inst_reg, mem_data_reg, fault}
// is queued per access and compared on the done pulse.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write, i_or_d, IR_write;
    logic [31:0] pc, alu_out, write_data, resp_data;
    logic        req_ready, resp_valid;
    logic        req_valid, req_we, stall, done, access_fault;
    logic [31:0] req_addr, req_wdata, inst_reg, mem_data_reg;

    int n_vec = 0;
    int n_err = 0;

    typedef logic [64:0] sb_t;
    sb_t sb[$];
    sb_t obs, exp_v;
    logic [31:0] exp_ir, exp_mdr;

    int          dc, ac, nr, ns;
    logic        st, we_s;
    logic [31:0] a_s, wd_s;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .IR_write(IR_write), .pc(pc), .alu_out(alu_out),
        .write_data(write_data), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
        .done(done), .inst_reg(inst_reg), .mem_data_reg(mem_data_reg),
        .access_fault(access_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; i_or_d = 0; IR_write = 0;
        pc = 0; alu_out = 0; write_data = 0;
        req_ready = 0; resp_valid = 0; resp_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        exp_ir = 0; exp_mdr = 0;
    endtask

    // Drives one access and plays the memory side; cycle 0 is the IDLE strobe cycle.
    task automatic run_access(input logic rd, wr, iod, irw,
                              input logic [31:0] a_pc, a_alu, wd,
                              input int ready_dly, resp_dly,
                              input logic [31:0] rdata,
                              output int done_cyc, accept_cyc, n_req, n_stall,
                              output logic stable, we_seen,
                              output logic [31:0] addr_seen, wdata_seen,
                              output sb_t o);
        bit acc;
        mem_read = rd; mem_write = wr; i_or_d = iod; IR_write = irw;
        pc = a_pc; alu_out = a_alu; write_data = wd;
        done_cyc = -1; accept_cyc = -1; n_req = 0; n_stall = 0;
        stable = 1; we_seen = 0; addr_seen = 0; wdata_seen = 0; o = '0; acc = 0;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            req_ready = 0; resp_valid = 0;
            if (stall) n_stall++;
            if (req_valid) begin
                if (n_req == 0) begin
                    addr_seen = req_addr; wdata_seen = req_wdata; we_seen = req_we;
                end else if (req_addr !== addr_seen || req_wdata !== wdata_seen ||
                             req_we !== we_seen) begin
                    stable = 0;
                end
                n_req++;
                if (n_req - 1 >= ready_dly) begin
                    req_ready = 1; accept_cyc = cyc; acc = 1;
                end
            end
            if (acc && resp_dly >= 0 && cyc == accept_cyc + 1 + resp_dly) begin
                resp_valid = 1; resp_data = rdata;
            end
            if (done) begin
                done_cyc = cyc;
                o = {inst_reg, mem_data_reg, access_fault};
                break;
            end
            tick();
        end
        mem_read = 0; mem_write = 0; req_ready = 0; resp_valid = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({req_valid, req_we, done, stall, access_fault} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {req_valid, req_we, done, stall, access_fault});
        end
        n_vec++;
        if ({inst_reg, mem_data_reg, req_addr, req_wdata} !== 128'h0) begin
            n_err++;
            $display("FAIL reset_regs: ir %h mdr %h addr %h wdata %h expected all 0",
                     inst_reg, mem_data_reg, req_addr, req_wdata);
        end
    endtask

    task automatic test_fetch(input logic [31:0] a, input logic [31:0] insn);
        exp_ir = insn;
        sb.push_back({exp_ir, exp_mdr, 1'b0});
        run_access(1, 0, 0, 1, a, 32'h0, 32'h0, 0, 0, insn,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (a_s !== a || we_s !== 1'b0) begin
            n_err++; $display("FAIL fetch_req: addr %h we %b expected %h 0", a_s, we_s, a);
        end
        n_vec++;
        if (ns !== 3 || dc !== 3) begin
            n_err++; $display("FAIL fetch_timing: stall cycles %0d done at %0d expected 3 3", ns, dc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL fetch_regs: got %h expected %h", obs, exp_v);
        end
        n_vec++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL fetch_idle: done %b stall %b expected 0 0", done, stall);
        end
    endtask

    task automatic test_load_backpressure();
        exp_mdr = 32'hDEADBEEF;
        sb.push_back({exp_ir, exp_mdr, 1'b0});
        run_access(1, 0, 1, 0, 32'h40, 32'h104, 32'h0, 3, 0, 32'hDEADBEEF,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (nr !== 4 || st !== 1'b1 || a_s !== 32'h104) begin
            n_err++; $display("FAIL load_bp_req: req cycles %0d stable %b addr %h expected 4 1 00000104", nr, st, a_s);
        end
        n_vec++;
        if (dc !== 6) begin
            n_err++; $display("FAIL load_bp_done: done at %0d expected 6", dc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL load_bp_regs: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_store();
        sb.push_back({exp_ir, exp_mdr, 1'b0});
        run_access(0, 1, 1, 0, 32'h0, 32'h200, 32'h1234, 0, -1, 32'h0,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (nr !== 1 || we_s !== 1'b1 || wd_s !== 32'h1234 || a_s !== 32'h200) begin
            n_err++; $display("FAIL store_req: reqs %0d we %b wdata %h addr %h expected 1 1 00001234 00000200", nr, we_s, wd_s, a_s);
        end
        n_vec++;
        if (dc !== 2 || ns !== 2) begin
            n_err++; $display("FAIL store_timing: done at %0d stall cycles %0d expected 2 2", dc, ns);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL store_regs: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_resp_at_timeout();
        exp_mdr = 32'h5A5A1234;
        sb.push_back({exp_ir, exp_mdr, 1'b0});
        run_access(1, 0, 1, 0, 32'h0, 32'h300, 32'h0, 0, 15, 32'h5A5A1234,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (dc - ac !== 17) begin
            n_err++; $display("FAIL resp_edge_timing: done-accept %0d expected 17", dc - ac);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL resp_edge_regs: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_fault_misaligned();
        do_reset();
        sb.push_back({exp_ir, exp_mdr, 1'b1});
        run_access(1, 0, 1, 0, 32'h0, 32'h102, 32'h0, 0, 0, 32'h11111111,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (nr !== 0 || dc !== 1 || ns !== 1) begin
            n_err++; $display("FAIL misalign_timing: reqs %0d done at %0d stall %0d expected 0 1 1", nr, dc, ns);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL misalign_regs: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_fault_conflict();
        do_reset();
        sb.push_back({exp_ir, exp_mdr, 1'b1});
        run_access(1, 1, 1, 0, 32'h0, 32'h100, 32'h77, 0, 0, 32'h22222222,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (nr !== 0 || dc !== 1) begin
            n_err++; $display("FAIL conflict_timing: reqs %0d done at %0d expected 0 1", nr, dc);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL conflict_regs: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        exp_mdr = 32'hCAFEF00D;
        sb.push_back({exp_ir, exp_mdr, 1'b0});
        run_access(1, 0, 1, 0, 32'h0, 32'h400, 32'h0, 0, 2, 32'hCAFEF00D,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL preload_regs: got %h expected %h", obs, exp_v);
        end
        sb.push_back({exp_ir, exp_mdr, 1'b1});
        run_access(1, 0, 1, 0, 32'h0, 32'h404, 32'h0, 0, -1, 32'h0,
                   dc, ac, nr, ns, st, we_s, a_s, wd_s, obs);
        n_vec++;
        if (dc - ac !== 17 || ac !== 1) begin
            n_err++; $display("FAIL timeout_timing: accept %0d done-accept %0d expected 1 17", ac, dc - ac);
        end
        exp_v = sb.pop_front();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++; $display("FAIL timeout_regs: got %h expected %h", obs, exp_v);
        end
        // Late response while idle must be dropped.
        resp_valid = 1; resp_data = 32'hBADBAD00;
        tick(); tick();
        resp_valid = 0;
        n_vec++;
        if (mem_data_reg !== exp_mdr || inst_reg !== exp_ir || done !== 1'b0) begin
            n_err++; $display("FAIL late_resp: mdr %h ir %h done %b expected %h %h 0", mem_data_reg, inst_reg, done, exp_mdr, exp_ir);
        end
    endtask

    task automatic test_reset_in_wait();
        int guard;
        mem_read = 1; i_or_d = 1; alu_out = 32'h500;
        guard = 0;
        #1;
        while (!req_valid && guard < 5) begin tick(); guard++; end
        req_ready = 1;
        tick();
        req_ready = 0;
        n_vec++;
        if (stall !== 1'b1 || req_valid !== 1'b0) begin
            n_err++; $display("FAIL wait_entry: stall %b req_valid %b expected 1 0", stall, req_valid);
        end
        reset = 1; resp_valid = 1; resp_data = 32'h0F0F0F0F;
        tick();
        reset = 0; resp_valid = 0; mem_read = 0;
        #1;
        exp_ir = 0; exp_mdr = 0;
        n_vec++;
        if ({req_valid, req_we, done, stall, access_fault} !== 5'b0 ||
            inst_reg !== 32'h0 || mem_data_reg !== 32'h0) begin
            n_err++; $display("FAIL reset_in_wait: ctrl %b ir %h mdr %h expected 00000 0 0",
                     {req_valid, req_we, done, stall, access_fault}, inst_reg, mem_data_reg);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || mem_data_reg !== 32'h0) begin
            n_err++; $display("FAIL reset_in_wait_idle: done %b mdr %h expected 0 0", done, mem_data_reg);
        end
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_fetch(32'h10, 32'h00500093);
        test_load_backpressure();
        test_store();
        test_resp_at_timeout();
        test_fault_misaligned();
        test_fault_conflict();
        test_timeout();
        test_reset_in_wait();
        test_fetch(32'h20, 32'h00A00113);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
